// File: rtl/chip8_selftest.sv
// chip8_selftest: programmable checkpoint sequencer. Pulses an active-low reset
// to the design under test, counts cycles after release, and compares the
// observation bus against a table of (cycle, expected, mask) checkpoints.
// Handshake: cfg_we and start are accepted only when busy is low (IDLE or
// DONE); while busy they are dropped without effect, there is no back-pressure.
module chip8_selftest #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int CYC_W        = 16,
  parameter int RESET_CYCLES = 1,
  parameter int STOP_ON_FAIL = 0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              CLOCK_50,
  input  logic              KEY0,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CYC_W-1:0]  cfg_cycle,
  input  logic [DATA_W-1:0] cfg_expect,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [CW-1:0]     num_checks,
  input  logic              start,
  input  logic [DATA_W-1:0] observe,
  output logic              dut_rst_n,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CW-1:0]     fail_count,
  output logic [AW-1:0]     first_fail_idx,
  output logic [DATA_W-1:0] first_fail_value
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic [CYC_W-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       num_q, num_d;
  logic [CW-1:0]       fail_q, fail_d;
  logic [AW-1:0]       ffi_q, ffi_d;
  logic [DATA_W-1:0]   ffv_q, ffv_d;
  logic                rst_n_q, rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                mismatch;

  // Checkpoint table: not reset, contents persist across runs and KEY0.
  logic [CYC_W-1:0]    cyc_tbl [DEPTH];
  logic [DATA_W-1:0]   exp_tbl [DEPTH];
  logic [DATA_W-1:0]   msk_tbl [DEPTH];

  // Table write port, only open while not busy.
  always_ff @(posedge CLOCK_50) begin
    if (KEY0 && cfg_we && (state_q == S_IDLE || state_q == S_DONE)) begin
      cyc_tbl[cfg_addr] <= cfg_cycle;
      exp_tbl[cfg_addr] <= cfg_expect;
      msk_tbl[cfg_addr] <= cfg_mask;
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    num_d    = num_q;
    fail_d   = fail_q;
    ffi_d    = ffi_q;
    ffv_d    = ffv_q;
    rst_n_d  = rst_n_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mismatch = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        rst_n_d = 1'b1;
        if (start) begin
          state_d = S_RESET;
          rcnt_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
          num_d   = (num_checks > DEPTH_C) ? DEPTH_C : num_checks;
          fail_d  = '0;
          ffi_d   = '0;
          ffv_d   = '0;
          rst_n_d = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_RESET: begin
        if (rcnt_q == RST_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          rst_n_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      S_RUN: begin
        if (cnt_q != {CYC_W{1'b1}}) cnt_d = cnt_q + CYC_W'(1);
        if (idx_q >= num_q) begin
          // Only reachable with an empty table: one RUN cycle, then pass.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_q == '0);
        end else if (cnt_q >= cyc_tbl[idx_q[AW-1:0]]) begin
          mismatch = |((observe ^ exp_tbl[idx_q[AW-1:0]]) & msk_tbl[idx_q[AW-1:0]]);
          idx_d    = idx_q + CW'(1);
          if (mismatch) begin
            if (fail_q != DEPTH_C) fail_d = fail_q + CW'(1);
            if (fail_q == '0) begin
              ffi_d = idx_q[AW-1:0];
              ffv_d = observe;
            end
          end
          if ((idx_d == num_q) || (mismatch && (STOP_ON_FAIL != 0))) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_d == '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
      ffv_q   <= '0;
      rst_n_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_rst_n        = rst_n_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_value = ffv_q;

endmodule

// File: tb/tb_chip8_selftest.sv
// Directed bench for chip8_selftest. Three instances share all inputs:
// default parameters, STOP_ON_FAIL=1, and RESET_CYCLES=3.
module tb_chip8_selftest;
  localparam int DATA_W = 8;
  localparam int CYC_W  = 16;
  localparam int AW     = 2;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              key0 = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [CYC_W-1:0]  cfg_cycle = '0;
  logic [DATA_W-1:0] cfg_expect = '0;
  logic [DATA_W-1:0] cfg_mask = '0;
  logic [CW-1:0]     num_checks = '0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] observe = '0;

  logic dut_rst_n, busy, done, pass;
  logic [CW-1:0] fail_count;
  logic [AW-1:0] ffi;
  logic [DATA_W-1:0] ffv;
  logic dut_rst_n_s, busy_s, done_s, pass_s;
  logic [CW-1:0] fail_count_s;
  logic [AW-1:0] ffi_s;
  logic [DATA_W-1:0] ffv_s;
  logic dut_rst_n_r, busy_r, done_r, pass_r;
  logic [CW-1:0] fail_count_r;
  logic [AW-1:0] ffi_r;
  logic [DATA_W-1:0] ffv_r;

  int checks = 0;
  int errors = 0;

  chip8_selftest u_dut (
    .CLOCK_50(clk), .KEY0(key0), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_cycle(cfg_cycle), .cfg_expect(cfg_expect), .cfg_mask(cfg_mask),
    .num_checks(num_checks), .start(start), .observe(observe),
    .dut_rst_n(dut_rst_n), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_idx(ffi), .first_fail_value(ffv)
  );

  chip8_selftest #(.STOP_ON_FAIL(1)) u_sof (
    .CLOCK_50(clk), .KEY0(key0), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_cycle(cfg_cycle), .cfg_expect(cfg_expect), .cfg_mask(cfg_mask),
    .num_checks(num_checks), .start(start), .observe(observe),
    .dut_rst_n(dut_rst_n_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail_count(fail_count_s), .first_fail_idx(ffi_s), .first_fail_value(ffv_s)
  );

  chip8_selftest #(.RESET_CYCLES(3)) u_r3 (
    .CLOCK_50(clk), .KEY0(key0), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_cycle(cfg_cycle), .cfg_expect(cfg_expect), .cfg_mask(cfg_mask),
    .num_checks(num_checks), .start(start), .observe(observe),
    .dut_rst_n(dut_rst_n_r), .busy(busy_r), .done(done_r), .pass(pass_r),
    .fail_count(fail_count_r), .first_fail_idx(ffi_r), .first_fail_value(ffv_r)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are read 1ns after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_entry(input int a, input int c, input int e, input int m);
    cfg_we     = 1'b1;
    cfg_addr   = AW'(a);
    cfg_cycle  = CYC_W'(c);
    cfg_expect = DATA_W'(e);
    cfg_mask   = DATA_W'(m);
    tick();
    cfg_we = 1'b0;
  endtask

  // Pulse start, return edges after the start edge until done (300 = timeout).
  task automatic run_to_done(output int cycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 300) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    key0 = 1'b0;
    tick(2);
    checks++; if (dut_rst_n !== 1'b0) begin errors++; $display("FAIL reset_dut_rst_n: got %b expected 0", dut_rst_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
    checks++; if (fail_count !== 3'd0) begin errors++; $display("FAIL reset_fail_count: got %0d expected 0", fail_count); end
    key0 = 1'b1;
    tick();
    checks++; if (dut_rst_n !== 1'b1) begin errors++; $display("FAIL reset_release: got %b expected 1", dut_rst_n); end
  endtask

  task automatic test_smoke();
    write_entry(0, 0, 8'h00, 8'hFF);
    write_entry(1, 2, 88, 8'hFF);
    num_checks = 3'd2;
    observe = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (dut_rst_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL smoke_reset_phase: rst_n=%b busy=%b expected 0 1", dut_rst_n, busy); end
    tick();
    checks++; if (dut_rst_n !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL smoke_run_phase: rst_n=%b busy=%b expected 1 1", dut_rst_n, busy); end
    tick();
    observe = 8'd88;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL smoke_early_done: got %b expected 0", done); end
    tick();
    checks++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL smoke_done: done=%b pass=%b busy=%b expected 1 1 0", done, pass, busy); end
    checks++; if (fail_count !== 3'd0) begin errors++; $display("FAIL smoke_fail_count: got %0d expected 0", fail_count); end
  endtask

  task automatic test_masked();
    int cyc;
    tick(4);
    write_entry(0, 3, 8'hA5, 8'h0F);
    num_checks = 3'd1;
    observe = 8'h35;
    run_to_done(cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL masked_latency: got %0d expected 5", cyc); end
    checks++; if (pass !== 1'b1 || fail_count !== 3'd0) begin errors++; $display("FAIL masked_pass: pass=%b fails=%0d expected 1 0", pass, fail_count); end
    observe = 8'h34;
    run_to_done(cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL masked_fail_latency: got %0d expected 5", cyc); end
    checks++; if (pass !== 1'b0 || fail_count !== 3'd1) begin errors++; $display("FAIL masked_fail: pass=%b fails=%0d expected 0 1", pass, fail_count); end
    checks++; if (ffi !== 2'd0 || ffv !== 8'h34) begin errors++; $display("FAIL masked_first: idx=%0d val=%h expected 0 34", ffi, ffv); end
  endtask

  task automatic load_multi();
    write_entry(0, 5, 8'h10, 8'hFF);
    write_entry(1, 5, 8'h20, 8'hFF);
    write_entry(2, 5, 8'h30, 8'h00);
    write_entry(3, 5, 8'h11, 8'h01);
  endtask

  task automatic test_multi();
    int dm;
    int ds;
    tick(4);
    load_multi();
    num_checks = 3'd4;
    observe = 8'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    dm = 0;
    ds = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done && dm == 0) dm = k;
      if (done_s && ds == 0) ds = k;
    end
    checks++; if (dm != 10) begin errors++; $display("FAIL multi_latency: got %0d expected 10", dm); end
    checks++; if (fail_count !== 3'd2 || ffi !== 2'd1 || ffv !== 8'h10) begin errors++; $display("FAIL multi_results: fails=%0d idx=%0d val=%h expected 2 1 10", fail_count, ffi, ffv); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL multi_pass: got %b expected 0", pass); end
    checks++; if (ds != 8) begin errors++; $display("FAIL stop_latency: got %0d expected 8", ds); end
    checks++; if (fail_count_s !== 3'd1 || ffi_s !== 2'd1) begin errors++; $display("FAIL stop_results: fails=%0d idx=%0d expected 1 1", fail_count_s, ffi_s); end
  endtask

  task automatic test_ignore();
    int n;
    tick(4);
    write_entry(0, 20, 8'h5A, 8'hFF);
    num_checks = 3'd1;
    observe = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_cycle = 16'd0;
    cfg_expect = 8'h00;
    cfg_mask = 8'hFF;
    start = 1'b1;
    tick();
    cfg_we = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ignore_busy: busy=%b done=%b expected 1 0", busy, done); end
    n = 6;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    checks++; if (n != 22) begin errors++; $display("FAIL ignore_latency: got %0d expected 22", n); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ignore_pass: got %b expected 1", pass); end
  endtask

  task automatic test_abort();
    tick(4);
    write_entry(0, 0, 8'h00, 8'hFF);
    write_entry(1, 100, 8'h00, 8'hFF);
    num_checks = 3'd2;
    observe = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    checks++; if (busy !== 1'b1 || fail_count !== 3'd1 || ffv !== 8'h5A) begin errors++; $display("FAIL abort_prerun: busy=%b fails=%0d val=%h expected 1 1 5a", busy, fail_count, ffv); end
    key0 = 1'b0;
    tick();
    checks++; if (dut_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL abort_flags: rst_n=%b busy=%b done=%b pass=%b expected 0 0 0 0", dut_rst_n, busy, done, pass); end
    checks++; if (fail_count !== 3'd0 || ffi !== 2'd0 || ffv !== 8'h00) begin errors++; $display("FAIL abort_results: fails=%0d idx=%0d val=%h expected 0 0 00", fail_count, ffi, ffv); end
    key0 = 1'b1;
    tick();
    checks++; if (dut_rst_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_release: rst_n=%b busy=%b expected 1 0", dut_rst_n, busy); end
  endtask

  task automatic test_edge();
    int dm;
    int dr;
    int lo_m;
    int lo_r;
    int cyc;
    tick(4);
    num_checks = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    dm = 0;
    dr = 0;
    lo_m = (dut_rst_n == 1'b0) ? 1 : 0;
    lo_r = (dut_rst_n_r == 1'b0) ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done && dm == 0) dm = k;
      if (done_r && dr == 0) dr = k;
      if (dut_rst_n == 1'b0) lo_m++;
      if (dut_rst_n_r == 1'b0) lo_r++;
    end
    checks++; if (dm != 2 || pass !== 1'b1) begin errors++; $display("FAIL empty_done: latency=%0d pass=%b expected 2 1", dm, pass); end
    checks++; if (lo_m != 1) begin errors++; $display("FAIL rst_low_r1: got %0d expected 1", lo_m); end
    checks++; if (lo_r != 3) begin errors++; $display("FAIL rst_low_r3: got %0d expected 3", lo_r); end
    checks++; if (dr != 4 || pass_r !== 1'b1) begin errors++; $display("FAIL empty_done_r3: latency=%0d pass=%b expected 4 1", dr, pass_r); end
    // num_checks above DEPTH is clamped to the full table.
    load_multi();
    num_checks = 3'd7;
    observe = 8'h10;
    run_to_done(cyc);
    checks++; if (cyc != 10 || fail_count !== 3'd2) begin errors++; $display("FAIL clamp_run: latency=%0d fails=%0d expected 10 2", cyc, fail_count); end
  endtask

  initial begin
    test_reset();
    test_smoke();
    test_masked();
    test_multi();
    test_ignore();
    test_abort();
    test_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_selftest.md
# chip8_selftest

Parametrised self-checking sequencer for the chip8 core: it resets the DUT, counts cycles after reset release, and compares a DUT observation bus (e.g. `LED`) against a programmable table of (cycle, expected, mask) checkpoints. It synthesises alongside `chip8` and `ram2`, so a check sequence runs on the FPGA or in simulation without `$display`/`$stop`. Results are reported on pass/fail/diagnostic outputs.

## Interface

- `DATA_W`, 8, width of the observation bus and expected/mask values
- `DEPTH`, 4, number of checkpoint table entries (≥1)
- `CYC_W`, 16, width of checkpoint cycle field and run counter
- `RESET_CYCLES`, 1, cycles `dut_rst_n` is held low per run (≥1)
- `STOP_ON_FAIL`, 0, 1 = end the run at the first mismatch

Ports:
- `CLOCK_50`  in  1  sole clock, all logic on rising edge
- `KEY0`  in  1  reset, synchronous, active-low
- `cfg_we`  in  1  write checkpoint entry `cfg_addr`
- `cfg_addr`  in  clog2(DEPTH)  entry index
- `cfg_cycle`  in  CYC_W  run cycle at which entry is due
- `cfg_expect`  in  DATA_W  expected value
- `cfg_mask`  in  DATA_W  1 = bit compared
- `num_checks`  in  clog2(DEPTH+1)  active entries, sampled on start
- `start`  in  1  begin a run (one-cycle pulse or level)
- `observe`  in  DATA_W  DUT value under test
- `dut_rst_n`  out  1  active-low reset to DUT
- `busy`  out  1  in RESET or RUN
- `done`  out  1  run complete, held until next start/reset
- `pass`  out  1  done and fail_count == 0
- `fail_count`  out  clog2(DEPTH+1)  mismatching entries
- `first_fail_idx`  out  clog2(DEPTH)  index of first mismatch
- `first_fail_value`  out  DATA_W  `observe` at first mismatch

## Operation

- States: IDLE, RESET, RUN, DONE. All outputs registered.
- `KEY0` low (any state, mid-run included): state IDLE, `dut_rst_n`=0, `busy`=`done`=`pass`=0, `fail_count`/`first_fail_idx`/`first_fail_value`=0, pointer and counters 0. Table contents not cleared (undefined after power-up).
- IDLE: `dut_rst_n`=1. `cfg_we` writes entry. `start` → RESET, latches `num_checks` (values > DEPTH clamp to DEPTH), clears results.
- RESET: `dut_rst_n`=0 for exactly RESET_CYCLES cycles, then → RUN with run counter = 0.
- RUN: `dut_rst_n`=1; run counter increments each cycle, saturates at all-ones. Current entry `idx` is evaluated on the first RUN cycle where counter ≥ `cycle[idx]`; at most one entry per cycle, so equal cycle values evaluate on consecutive cycles. Entries are expected in non-decreasing cycle order; an out-of-order entry evaluates immediately after its predecessor.
- Compare: mismatch iff `((observe ^ expect) & mask) != 0`; mask 0 always passes. On mismatch, `fail_count` += 1 (saturating at DEPTH); if first mismatch, capture `idx` and `observe`.
- RUN → DONE when `idx` reaches `num_checks`, or on first mismatch when STOP_ON_FAIL=1. `num_checks`=0: one RUN cycle, then DONE with pass.
- DONE: `done`=1, `pass` = (`fail_count`==0), `dut_rst_n`=1, `cfg_we` honoured; `start` restarts as from IDLE.
- `cfg_we` and `start` are ignored while `busy`.

## Timing

- `start` sampled at edge T → `busy`=1, `dut_rst_n`=0 from T+1 through T+RESET_CYCLES; first RUN cycle (counter 0, `dut_rst_n`=1) at T+RESET_CYCLES+1.
- Entry with cycle c and no backlog: evaluates `observe` sampled at edge T+RESET_CYCLES+1+c.
- `done`/`pass`/results valid one cycle after the last evaluation edge; `busy` drops same cycle.
- Config write at edge E is visible to a `start` sampled at E+1.
- Run-counter saturation: entries with cycle = 2^CYC_W−1 still evaluate (≥ compare).

## Test plan

- Reset: `KEY0`=0 two cycles → `dut_rst_n`=0, `busy`=`done`=`pass`=0, `fail_count`=0; release → `dut_rst_n`=1 next cycle.
- chip8 smoke: entries {c=0,exp=0x00,mask=0xFF},{c=2,exp=88,mask=0xFF}, num_checks=2, DUT produces 0 then 88 → `done`=1, `pass`=1, `dut_rst_n` low exactly 1 cycle.
- Masked failure: entry {c=3,exp=0xA5,mask=0x0F}, observe=0x35 → pass; observe=0x34 → `fail_count`=1, `first_fail_idx`=0, `first_fail_value`=0x34.
- Multi-fail and duplicates: 4 entries all c=5, entries 1 and 3 mismatch, STOP_ON_FAIL=0 → evaluated run cycles 5–8, `fail_count`=2, `first_fail_idx`=1; STOP_ON_FAIL=1 → `done` one cycle after run cycle 6, `fail_count`=1.
- Abort/ignore: `KEY0` low mid-RUN → all outputs at reset values next cycle; `cfg_we` and second `start` during RUN → table and run unaffected.
- Edge: num_checks=0 → `done`=`pass`=1 at T+RESET_CYCLES+2; RESET_CYCLES=3 → `dut_rst_n` low exactly 3 cycles.
